cpu_bus_arbiter: RTL and testbench
==================================

# cpu_bus_arbiter

Shares one downstream memory port between the core's instruction bus and data bus. Sits between the pipeline's fetch/memory stages and the memory/cache side. Accepts at most one transaction at a time, arbitrates round-robin on contention, and returns responses to the requester that owns the transaction. Single outstanding request; no reordering.

## Interface
Parameters: none. Size encoding: 0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes.
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- i_valid  in  1  instruction fetch request pending
- i_addr  in  32  fetch address
- i_addr_ok  out  1  fetch request accepted this cycle
- i_data_ok  out  1  fetch response valid this cycle
- i_data  out  32  fetch response data
- d_valid  in  1  data request pending
- d_addr  in  32  data address
- d_size  in  3  access size
- d_strobe  in  4  byte write enables; nonzero means write
- d_wdata  in  32  write data
- d_addr_ok  out  1  data request accepted this cycle
- d_data_ok  out  1  data response valid this cycle
- d_data  out  32  data response (read data; don't-care for writes)
- m_valid  out  1  downstream request valid
- m_write  out  1  downstream request is a write
- m_addr  out  32  downstream address
- m_size  out  3  downstream size (always 2 for fetches)
- m_strobe  out  4  downstream byte enables (0 for fetches)
- m_wdata  out  32  downstream write data
- m_ready  in  1  downstream accepts request when m_valid & m_ready
- m_rvalid  in  1  downstream response valid (one-cycle pulse)
- m_rdata  in  32  downstream response data

## Operation
- FSM: IDLE, REQ, WAIT, RESP.
- IDLE: if neither valid, stay. If exactly one valid, grant it. If both valid, grant the requester not granted last (last_grant register). Then:
  - assert that requester's *_addr_ok combinationally in this cycle
  - latch addr/size/strobe/wdata into the request buffer, record owner, update last_grant
  - go to REQ
- REQ: drive m_* from the request buffer with m_valid=1. On m_ready go to WAIT. Otherwise stay, holding all m_* stable.
- WAIT: m_valid=0. On m_rvalid capture m_rdata into the response register and go to RESP.
- RESP: assert the owner's *_data_ok for exactly one cycle, with i_data/d_data driven from the response register. Go to IDLE.
- Writes complete the same way: downstream still returns m_rvalid, and d_data_ok pulses.
- Requesters hold valid and fields stable until addr_ok. Inputs are not sampled outside IDLE.
- i_data and d_data both show the response register at all times; only the data_ok strobes are qualified by owner.
- m_write = (m_strobe != 0). Fetch buffer entries use size 2 and strobe 0.

## Timing
- Reset values: state=IDLE; last_grant=ibus, so the first contention goes to dbus; response register=0; all outputs 0.
- Reset in any state aborts the transaction. Outputs are 0 in the following cycle, and no data_ok is issued for the aborted request. Downstream is reset on the same edge.
- addr_ok is combinational in the request cycle T. m_valid rises at T+1.
- m_ready at cycle R → WAIT from R+1. m_rvalid is legal from R+1 onward, including R+1 itself.
- m_rvalid at cycle V → data_ok at V+1. IDLE at V+2, which can accept a new request with addr_ok at V+2.
- Minimum request-to-data_ok latency: 3 cycles (T addr_ok, T+1 m_ready, T+2 m_rvalid, T+3 data_ok).
- Minimum back-to-back spacing between addr_ok pulses: 4 cycles.
- Never more than one of i_addr_ok/d_addr_ok, or one of i_data_ok/d_data_ok, high in a cycle.
- m_rvalid outside WAIT is ignored. m_ready outside REQ is ignored.

## Test plan
- Single fetch: i_valid, i_addr=0xBFC0_0000, m_ready tied 1, m_rvalid one cycle after handshake, m_rdata=0x2408_0001 → i_addr_ok at T, m_valid/m_size=2/m_write=0 at T+1, i_data_ok with i_data=0x2408_0001 at T+3.
- Byte store: d_valid, d_addr=0x8000_0013, d_size=0, d_strobe=4'b1000, d_wdata=0xAB00_0000 → m_write=1, m_strobe=4'b1000, m_addr=0x8000_0013; d_data_ok one cycle after m_rvalid.
- Contention: i_valid and d_valid both held high from reset → grants alternate d, i, d, i. Each addr_ok is ≥4 cycles apart.
- Backpressure: m_ready low for 5 cycles → m_valid and all m_* fields stable for 5 cycles. Data_ok follows m_rvalid by 1.
- Reset mid-WAIT: assert reset while awaiting m_rvalid, then send m_rvalid after reset → no data_ok, state IDLE, outputs 0. Next contention grants dbus first.
- Stray signals: m_rvalid pulsed in IDLE and m_ready toggled in WAIT → no state change, no data_ok.

Source files
------------

// File: rtl/cpu_bus_arbiter_if.sv
// Port bundle for cpu_bus_arbiter: instruction bus, data bus and the shared downstream memory port.
interface cpu_bus_arbiter_if;
    logic        i_valid;
    logic [31:0] i_addr;
    logic        i_addr_ok;
    logic        i_data_ok;
    logic [31:0] i_data;

    logic        d_valid;
    logic [31:0] d_addr;
    logic [2:0]  d_size;
    logic [3:0]  d_strobe;
    logic [31:0] d_wdata;
    logic        d_addr_ok;
    logic        d_data_ok;
    logic [31:0] d_data;

    logic        m_valid;
    logic        m_write;
    logic [31:0] m_addr;
    logic [2:0]  m_size;
    logic [3:0]  m_strobe;
    logic [31:0] m_wdata;
    logic        m_ready;
    logic        m_rvalid;
    logic [31:0] m_rdata;

    // Arbiter side.
    modport slave (
        input  i_valid, i_addr,
        output i_addr_ok, i_data_ok, i_data,
        input  d_valid, d_addr, d_size, d_strobe, d_wdata,
        output d_addr_ok, d_data_ok, d_data,
        output m_valid, m_write, m_addr, m_size, m_strobe, m_wdata,
        input  m_ready, m_rvalid, m_rdata
    );

    // Requesters plus memory side.
    modport master (
        output i_valid, i_addr,
        input  i_addr_ok, i_data_ok, i_data,
        output d_valid, d_addr, d_size, d_strobe, d_wdata,
        input  d_addr_ok, d_data_ok, d_data,
        input  m_valid, m_write, m_addr, m_size, m_strobe, m_wdata,
        output m_ready, m_rvalid, m_rdata
    );
endinterface

// File: rtl/cpu_bus_arbiter.sv
// Round-robin arbiter sharing one single-outstanding memory port between the fetch and data buses.
module cpu_bus_arbiter (
    input  logic             clk,
    input  logic             reset,
    cpu_bus_arbiter_if.slave bus
);
    localparam int unsigned AddrW = 32;
    localparam int unsigned DataW = 32;
    localparam int unsigned SizeW = 3;
    localparam int unsigned StrbW = 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    localparam logic [SizeW-1:0] WordSize = SizeW'(2);

    logic [1:0]       state;
    logic [1:0]       stateNext;
    logic [AddrW-1:0] reqAddr;
    logic [SizeW-1:0] reqSize;
    logic [StrbW-1:0] reqStrobe;
    logic [DataW-1:0] reqWdata;
    logic             reqOwnerD;
    logic             lastGrantD;
    logic [DataW-1:0] respData;
    logic             grantI;
    logic             grantD;
    logic             inReq;
    logic             inResp;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    // Next state and grant decision; on contention the side not granted last wins.
    always_comb begin
        stateNext = state;
        grantI    = 1'b0;
        grantD    = 1'b0;
        case (state)
            IDLE: begin
                grantD = !reset && bus.d_valid && (!bus.i_valid || !lastGrantD);
                grantI = !reset && bus.i_valid && (!bus.d_valid || lastGrantD);
                if (grantI || grantD) stateNext = REQ;
            end
            REQ:     if (bus.m_ready)  stateNext = WAIT;
            WAIT:    if (bus.m_rvalid) stateNext = RESP;
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Request buffer, owner/last-grant tracking and response capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            reqAddr    <= '0;
            reqSize    <= '0;
            reqStrobe  <= '0;
            reqWdata   <= '0;
            reqOwnerD  <= 1'b0;
            lastGrantD <= 1'b0;
            respData   <= '0;
        end else begin
            if (grantD) begin
                reqAddr    <= bus.d_addr;
                reqSize    <= bus.d_size;
                reqStrobe  <= bus.d_strobe;
                reqWdata   <= bus.d_wdata;
                reqOwnerD  <= 1'b1;
                lastGrantD <= 1'b1;
            end else if (grantI) begin
                reqAddr    <= bus.i_addr;
                reqSize    <= WordSize;
                reqStrobe  <= '0;
                reqWdata   <= '0;
                reqOwnerD  <= 1'b0;
                lastGrantD <= 1'b0;
            end
            if (state == WAIT && bus.m_rvalid) respData <= bus.m_rdata;
        end
    end

    assign inReq  = (state == REQ);
    assign inResp = (state == RESP);

    assign bus.i_addr_ok = grantI;
    assign bus.d_addr_ok = grantD;
    assign bus.i_data_ok = inResp && !reqOwnerD;
    assign bus.d_data_ok = inResp && reqOwnerD;
    assign bus.i_data    = respData;
    assign bus.d_data    = respData;

    // Downstream fields are quiet outside the request phase.
    assign bus.m_valid  = inReq;
    assign bus.m_write  = inReq && (reqStrobe != '0);
    assign bus.m_addr   = inReq ? reqAddr   : '0;
    assign bus.m_size   = inReq ? reqSize   : '0;
    assign bus.m_strobe = inReq ? reqStrobe : '0;
    assign bus.m_wdata  = inReq ? reqWdata  : '0;
endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Self-checking bench for cpu_bus_arbiter: directed vector table, corner sequences, randomized model check.
module tb_cpu_bus_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cpu_bus_arbiter_if bus ();
    cpu_bus_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

    int unsigned nChecks = 0;
    int unsigned nPass   = 0;
    int unsigned cycleCnt = 0;
    int unsigned lastGrantCycle = 0;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    typedef struct {
        logic        iv, dv;
        logic [31:0] iAddr, dAddr;
        logic [2:0]  dSize;
        logic [3:0]  dStrobe;
        logic [31:0] dWdata, rdata;
        int unsigned readyDelay, rvDelay;
        logic        expD;
        logic [31:0] expMaddr;
        logic [2:0]  expMsize;
        logic [3:0]  expMstrobe;
        logic        expMwrite;
        logic [31:0] expMwdata;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        bus.i_valid = 1'b0; bus.i_addr = '0;
        bus.d_valid = 1'b0; bus.d_addr = '0; bus.d_size = '0; bus.d_strobe = '0; bus.d_wdata = '0;
        bus.m_ready = 1'b0; bus.m_rvalid = 1'b0; bus.m_rdata = '0;
    endtask

    // One complete transaction with fixed cycle-by-cycle expectations from the table row.
    task automatic runVec(input vec_t v, input int idx);
        string t;
        t = $sformatf("v%0d", idx);
        bus.i_valid = v.iv; bus.i_addr = v.iAddr;
        bus.d_valid = v.dv; bus.d_addr = v.dAddr; bus.d_size = v.dSize;
        bus.d_strobe = v.dStrobe; bus.d_wdata = v.dWdata;
        bus.m_ready = 1'b0; bus.m_rvalid = 1'b0;
        @(negedge clk);
        check({t, ".i_addr_ok"}, 32'(bus.i_addr_ok), 32'(!v.expD));
        check({t, ".d_addr_ok"}, 32'(bus.d_addr_ok), 32'(v.expD));
        if (idx >= 4) check({t, ".gap_ge4"}, 32'(cycleCnt - lastGrantCycle >= 4), 32'd1);
        lastGrantCycle = cycleCnt;
        nextCycle();
        if (!(v.iv && v.dv)) begin
            bus.i_valid = 1'b0; bus.d_valid = 1'b0;
            bus.i_addr = ~v.iAddr; bus.d_addr = ~v.dAddr; bus.d_strobe = ~v.dStrobe; bus.d_wdata = ~v.dWdata;
        end
        for (int c = 0; c <= int'(v.readyDelay); c++) begin
            bus.m_ready = (c == int'(v.readyDelay));
            @(negedge clk);
            check({t, ".m_valid"},  32'(bus.m_valid),  32'd1);
            check({t, ".m_addr"},   bus.m_addr,        v.expMaddr);
            check({t, ".m_size"},   32'(bus.m_size),   32'(v.expMsize));
            check({t, ".m_strobe"}, 32'(bus.m_strobe), 32'(v.expMstrobe));
            check({t, ".m_write"},  32'(bus.m_write),  32'(v.expMwrite));
            if (v.expMwrite) check({t, ".m_wdata"}, bus.m_wdata, v.expMwdata);
            check({t, ".busy_addr_ok"}, 32'(bus.i_addr_ok | bus.d_addr_ok), 32'd0);
            nextCycle();
        end
        for (int c = 0; c < int'(v.rvDelay); c++) begin
            bus.m_ready = c[0];
            @(negedge clk);
            check({t, ".wait_m_valid"}, 32'(bus.m_valid), 32'd0);
            check({t, ".wait_data_ok"}, 32'(bus.i_data_ok | bus.d_data_ok), 32'd0);
            nextCycle();
        end
        bus.m_ready = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = v.rdata;
        @(negedge clk);
        check({t, ".rv_m_valid"}, 32'(bus.m_valid), 32'd0);
        check({t, ".rv_data_ok"}, 32'(bus.i_data_ok | bus.d_data_ok), 32'd0);
        nextCycle();
        bus.m_rvalid = 1'b0; bus.m_rdata = ~v.rdata;
        @(negedge clk);
        check({t, ".i_data_ok"}, 32'(bus.i_data_ok), 32'(!v.expD));
        check({t, ".d_data_ok"}, 32'(bus.d_data_ok), 32'(v.expD));
        check({t, ".i_data"}, bus.i_data, v.rdata);
        check({t, ".d_data"}, bus.d_data, v.rdata);
        nextCycle();
    endtask

    // Transaction-level reference for the random phase.
    logic        busy, handshaken, respPending, lastWasD;
    logic [31:0] lastRdata;
    logic        txnD;
    logic [31:0] txnAddr, txnWdata;
    logic [2:0]  txnSize;
    logic [3:0]  txnStrobe;
    logic        iPend, dPend;
    logic [31:0] iA, dA, dW;
    logic [2:0]  dS;
    logic [3:0]  dSt;

    initial begin
        logic expGI, expGD, expMv;
        idleInputs();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst.m_valid", 32'(bus.m_valid), 32'd0);
        check("rst.m_addr", bus.m_addr, 32'd0);
        check("rst.data_ok", 32'({bus.i_data_ok, bus.d_data_ok}), 32'd0);
        check("rst.i_data", bus.i_data, 32'd0);
        check("rst.d_data", bus.d_data, 32'd0);
        nextCycle();

        // Order: iv dv iAddr dAddr dSize dStrobe dWdata rdata readyDelay rvDelay expD expMaddr expMsize expMstrobe expMwrite expMwdata
        vecs[0] = '{1'b1, 1'b0, 32'hBFC0_0000, 32'h0, 3'd0, 4'h0, 32'h0, 32'h2408_0001, 0, 0,
                    1'b0, 32'hBFC0_0000, 3'd2, 4'h0, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 32'h0, 32'h8000_0013, 3'd0, 4'b1000, 32'hAB00_0000, 32'hDEAD_BEEF, 0, 1,
                    1'b1, 32'h8000_0013, 3'd0, 4'b1000, 1'b1, 32'hAB00_0000};
        vecs[2] = '{1'b0, 1'b1, 32'h0, 32'h8000_1000, 3'd2, 4'h0, 32'h1111_1111, 32'h1234_5678, 5, 2,
                    1'b1, 32'h8000_1000, 3'd2, 4'h0, 1'b0, 32'h0};
        vecs[3] = '{1'b1, 1'b1, 32'hBFC0_0100, 32'h8000_0020, 3'd2, 4'hF, 32'hCAFE_F00D, 32'h0000_0003, 0, 0,
                    1'b1, 32'h8000_0020, 3'd2, 4'hF, 1'b1, 32'hCAFE_F00D};
        vecs[4] = '{1'b1, 1'b1, 32'hBFC0_0104, 32'h8000_0020, 3'd2, 4'hF, 32'hCAFE_F00D, 32'h0000_0004, 0, 0,
                    1'b0, 32'hBFC0_0104, 3'd2, 4'h0, 1'b0, 32'h0};
        vecs[5] = '{1'b1, 1'b1, 32'hBFC0_0108, 32'h8000_0042, 3'd1, 4'h0, 32'h0, 32'h0000_BEEF, 0, 0,
                    1'b1, 32'h8000_0042, 3'd1, 4'h0, 1'b0, 32'h0};
        vecs[6] = '{1'b1, 1'b1, 32'hBFC0_010C, 32'h8000_0042, 3'd1, 4'h0, 32'h0, 32'h0000_0006, 0, 0,
                    1'b0, 32'hBFC0_010C, 3'd2, 4'h0, 1'b0, 32'h0};

        for (int k = 0; k < 3; k++) runVec(vecs[k], k);

        // Stray m_rvalid in IDLE must neither respond nor overwrite the response register.
        idleInputs();
        bus.m_rvalid = 1'b1; bus.m_rdata = 32'hFEED_0000;
        @(negedge clk);
        check("stray.data_ok", 32'({bus.i_data_ok, bus.d_data_ok}), 32'd0);
        nextCycle();
        bus.m_rvalid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("stray.data_ok2", 32'({bus.i_data_ok, bus.d_data_ok}), 32'd0);
            check("stray.i_data", bus.i_data, 32'h1234_5678);
            check("stray.m_valid", 32'(bus.m_valid), 32'd0);
            nextCycle();
        end

        // Reset while awaiting m_rvalid aborts the transaction.
        bus.d_valid = 1'b1; bus.d_addr = 32'h8000_2000; bus.d_size = 3'd2; bus.d_strobe = 4'h0;
        @(negedge clk);
        check("rw.d_addr_ok", 32'(bus.d_addr_ok), 32'd1);
        nextCycle();
        bus.d_valid = 1'b0; bus.m_ready = 1'b1;
        nextCycle();
        bus.m_ready = 1'b0;
        nextCycle();
        reset = 1'b1;
        nextCycle();
        reset = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 32'h55AA_55AA;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rw.data_ok", 32'({bus.i_data_ok, bus.d_data_ok}), 32'd0);
            check("rw.m_valid", 32'(bus.m_valid), 32'd0);
            check("rw.m_addr", bus.m_addr, 32'd0);
            check("rw.d_data", bus.d_data, 32'd0);
            nextCycle();
            bus.m_rvalid = 1'b0;
        end

        lastGrantCycle = cycleCnt;
        for (int k = 3; k < 7; k++) runVec(vecs[k], k);

        // Randomized traffic against the transaction-level reference.
        busy = 1'b0; handshaken = 1'b0; respPending = 1'b0; lastWasD = 1'b0;
        lastRdata = vecs[6].rdata;
        iPend = 1'b0; dPend = 1'b0; iA = '0; dA = '0; dW = '0; dS = '0; dSt = '0;
        txnD = 1'b0; txnAddr = '0; txnWdata = '0; txnSize = '0; txnStrobe = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(199) == 0) begin
                reset = 1'b1; iPend = 1'b0; dPend = 1'b0;
            end else begin
                reset = 1'b0;
                if (!iPend && $urandom_range(2) == 0) begin iPend = 1'b1; iA = $urandom; end
                if (!dPend && $urandom_range(2) == 0) begin
                    dPend = 1'b1; dA = $urandom; dS = 3'($urandom_range(2));
                    dSt = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom); dW = $urandom;
                end
            end
            bus.i_valid = iPend; bus.i_addr = iA;
            bus.d_valid = dPend; bus.d_addr = dA; bus.d_size = dS; bus.d_strobe = dSt; bus.d_wdata = dW;
            bus.m_ready = 1'($urandom_range(1));
            bus.m_rvalid = ($urandom_range(2) == 0);
            bus.m_rdata = $urandom;
            @(negedge clk);
            expGI = !busy && iPend && (!dPend || lastWasD);
            expGD = !busy && dPend && (!iPend || !lastWasD);
            expMv = busy && !handshaken;
            if (!reset) begin
                check("rnd.i_addr_ok", 32'(bus.i_addr_ok), 32'(expGI));
                check("rnd.d_addr_ok", 32'(bus.d_addr_ok), 32'(expGD));
                check("rnd.i_data_ok", 32'(bus.i_data_ok), 32'(respPending && !txnD));
                check("rnd.d_data_ok", 32'(bus.d_data_ok), 32'(respPending && txnD));
                check("rnd.i_data", bus.i_data, lastRdata);
                check("rnd.d_data", bus.d_data, lastRdata);
                check("rnd.m_valid", 32'(bus.m_valid), 32'(expMv));
                if (expMv) begin
                    check("rnd.m_addr", bus.m_addr, txnAddr);
                    check("rnd.m_size", 32'(bus.m_size), 32'(txnSize));
                    check("rnd.m_strobe", 32'(bus.m_strobe), 32'(txnStrobe));
                    check("rnd.m_write", 32'(bus.m_write), 32'(txnStrobe != 4'h0));
                    if (txnStrobe != 4'h0) check("rnd.m_wdata", bus.m_wdata, txnWdata);
                end
            end
            if (reset) begin
                busy = 1'b0; handshaken = 1'b0; respPending = 1'b0; lastWasD = 1'b0; lastRdata = '0;
            end else if (!busy) begin
                if (expGD) begin
                    busy = 1'b1; handshaken = 1'b0; txnD = 1'b1; lastWasD = 1'b1;
                    txnAddr = dA; txnSize = dS; txnStrobe = dSt; txnWdata = dW; dPend = 1'b0;
                end else if (expGI) begin
                    busy = 1'b1; handshaken = 1'b0; txnD = 1'b0; lastWasD = 1'b0;
                    txnAddr = iA; txnSize = 3'd2; txnStrobe = 4'h0; txnWdata = '0; iPend = 1'b0;
                end
            end else if (respPending) begin
                busy = 1'b0; respPending = 1'b0;
            end else if (!handshaken) begin
                if (bus.m_ready) handshaken = 1'b1;
            end else if (bus.m_rvalid) begin
                respPending = 1'b1; lastRdata = bus.m_rdata;
            end
            nextCycle();
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
